// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core request/response and memory bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    // core 0 side
    logic              c0_req;
    logic              c0_we;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_lock;
    logic              c0_gnt;
    logic [DATA_W-1:0] c0_rdata;
    logic              c0_rvalid;

    // core 1 side
    logic              c1_req;
    logic              c1_we;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_lock;
    logic              c1_gnt;
    logic [DATA_W-1:0] c1_rdata;
    logic              c1_rvalid;

    // single-port memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_load;
    logic              mem_store;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter view
    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata, c0_lock,
        output c0_gnt, c0_rdata, c0_rvalid,
        input  c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
        output c1_gnt, c1_rdata, c1_rvalid,
        output mem_address, mem_wdata, mem_load, mem_store,
        input  mem_rdata
    );

    // cores-plus-memory view
    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata, c0_lock,
        input  c0_gnt, c0_rdata, c0_rvalid,
        output c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
        input  c1_gnt, c1_rdata, c1_rvalid,
        input  mem_address, mem_wdata, mem_load, mem_store,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-core round-robin data memory arbiter; lock ownership enabled by DMEM_ARB_LOCK_EN
module dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_FREE = 2'd0,
        OWN_C0   = 2'd1,
        OWN_C1   = 2'd2
    } own_e;

    own_e              own_q;
    own_e              own_d;
    logic              ptr_q;
    logic [DATA_W-1:0] c0_rdata_q;
    logic [DATA_W-1:0] c1_rdata_q;
    logic              c0_rvalid_q;
    logic              c1_rvalid_q;

    logic              gnt0;
    logic              gnt1;

    // Grant select: the owner is exclusive, otherwise a lone requester wins and ties go to ptr.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (own_q)
                OWN_C0: gnt0 = bus.c0_req;
                OWN_C1: gnt1 = bus.c1_req;
                default: begin
                    if (bus.c0_req && bus.c1_req) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = bus.c0_req;
                        gnt1 = bus.c1_req;
                    end
                end
            endcase
        end
    end

    // Memory port mux: the granted core's request, all-zero when idle.
    always_comb begin
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.mem_load    = 1'b0;
        bus.mem_store   = 1'b0;
        if (gnt0) begin
            bus.mem_address = bus.c0_addr;
            bus.mem_wdata   = bus.c0_wdata;
            bus.mem_load    = ~bus.c0_we;
            bus.mem_store   = bus.c0_we;
        end else if (gnt1) begin
            bus.mem_address = bus.c1_addr;
            bus.mem_wdata   = bus.c1_wdata;
            bus.mem_load    = ~bus.c1_we;
            bus.mem_store   = bus.c1_we;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Ownership next state: taken by a granted locked access, held until the owner's lock drops.
    always_comb begin
        own_d = own_q;
        case (own_q)
            OWN_FREE: begin
                if (gnt0 && bus.c0_lock) begin
                    own_d = OWN_C0;
                end else if (gnt1 && bus.c1_lock) begin
                    own_d = OWN_C1;
                end
            end
            OWN_C0: if (!bus.c0_lock) own_d = OWN_FREE;
            OWN_C1: if (!bus.c1_lock) own_d = OWN_FREE;
            default: own_d = OWN_FREE;
        endcase
    end
`else
    logic unused_lock;
    assign unused_lock = bus.c0_lock | bus.c1_lock;
    assign own_d       = OWN_FREE;
`endif

    // Arbiter state: ownership, fairness pointer and per-core load return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q       <= OWN_FREE;
            ptr_q       <= 1'b0;
            c0_rdata_q  <= '0;
            c1_rdata_q  <= '0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
        end else begin
            own_q <= own_d;
            if (gnt0) begin
                ptr_q <= 1'b1;
            end else if (gnt1) begin
                ptr_q <= 1'b0;
            end
            c0_rvalid_q <= gnt0 & ~bus.c0_we;
            c1_rvalid_q <= gnt1 & ~bus.c1_we;
            if (gnt0 && !bus.c0_we) begin
                c0_rdata_q <= bus.mem_rdata;
            end
            if (gnt1 && !bus.c1_we) begin
                c1_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.c0_gnt    = gnt0;
    assign bus.c1_gnt    = gnt1;
    assign bus.c0_rdata  = c0_rdata_q;
    assign bus.c1_rdata  = c1_rdata_q;
    assign bus.c0_rvalid = c0_rvalid_q;
    assign bus.c1_rvalid = c1_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed-vector bench for dmem_arbiter with a behavioural single-port memory
module tb_dmem_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec;
    int   n_err;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // memory model: asynchronous read, store at the edge, preset to 0x1000+addr on reset
    logic [DW-1:0] mem [16];
    assign bus.mem_rdata = mem[bus.mem_address];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000 + i;
        end else if (bus.mem_store) begin
            mem[bus.mem_address] <= bus.mem_wdata;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c0(input logic req, input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic lock);
        bus.c0_req   = req;
        bus.c0_we    = we;
        bus.c0_addr  = addr;
        bus.c0_wdata = wdata;
        bus.c0_lock  = lock;
    endtask

    task automatic drive_c1(input logic req, input logic we, input logic [3:0] addr,
                            input logic [31:0] wdata, input logic lock);
        bus.c1_req   = req;
        bus.c1_we    = we;
        bus.c1_addr  = addr;
        bus.c1_wdata = wdata;
        bus.c1_lock  = lock;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive_c0(1'b1, 1'b0, 4'd7, 32'h0, 1'b1);
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);

        // reset state, request present but never granted
        cyc;
        cyc;
        #2;
        check_vec("rst_c0_gnt", bus.c0_gnt, 0);
        check_vec("rst_c1_gnt", bus.c1_gnt, 0);
        check_vec("rst_mem_load", bus.mem_load, 0);
        check_vec("rst_mem_store", bus.mem_store, 0);
        check_vec("rst_mem_addr", bus.mem_address, 0);
        check_vec("rst_mem_wdata", bus.mem_wdata, 0);
        check_vec("rst_c0_rvalid", bus.c0_rvalid, 0);
        check_vec("rst_c1_rvalid", bus.c1_rvalid, 0);
        check_vec("rst_c0_rdata", bus.c0_rdata, 0);
        check_vec("rst_c1_rdata", bus.c1_rdata, 0);

        // store by core 0 then load of the same word by core 1
        cyc;
        reset = 1'b0;
        drive_c0(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
        #2;
        check_vec("st_c0_gnt", bus.c0_gnt, 1);
        check_vec("st_c1_gnt", bus.c1_gnt, 0);
        check_vec("st_mem_store", bus.mem_store, 1);
        check_vec("st_mem_load", bus.mem_load, 0);
        check_vec("st_mem_addr", bus.mem_address, 3);
        check_vec("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        drive_c1(1'b1, 1'b0, 4'd3, 32'h0, 1'b0);
        #2;
        check_vec("ld_c1_gnt", bus.c1_gnt, 1);
        check_vec("ld_mem_load", bus.mem_load, 1);
        check_vec("ld_mem_addr", bus.mem_address, 3);
        check_vec("st_no_rvalid", bus.c0_rvalid, 0);
        cyc;
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        check_vec("ld_c1_rvalid", bus.c1_rvalid, 1);
        check_vec("ld_c1_rdata", bus.c1_rdata, 32'hDEADBEEF);
        check_vec("ld_c0_rvalid", bus.c0_rvalid, 0);
        cyc;
        #2;
        check_vec("ld_rvalid_drop", bus.c1_rvalid, 0);
        check_vec("ld_rdata_hold", bus.c1_rdata, 32'hDEADBEEF);

        // both cores load every cycle from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        drive_c0(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        drive_c1(1'b1, 1'b0, 4'd2, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #2;
            check_vec($sformatf("alt_c0_gnt_%0d", k), bus.c0_gnt, (k % 2) == 0);
            check_vec($sformatf("alt_c1_gnt_%0d", k), bus.c1_gnt, (k % 2) == 1);
            check_vec($sformatf("alt_c0_rv_%0d", k), bus.c0_rvalid, (k >= 1) && ((k - 1) % 2 == 0));
            check_vec($sformatf("alt_c1_rv_%0d", k), bus.c1_rvalid, (k >= 1) && ((k - 1) % 2 == 1));
            cyc;
        end
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        check_vec("alt_c1_rv_last", bus.c1_rvalid, 1);
        check_vec("alt_c0_rv_last", bus.c0_rvalid, 0);
        check_vec("alt_c0_rdata", bus.c0_rdata, 32'h1001);
        check_vec("alt_c1_rdata", bus.c1_rdata, 32'h1002);
        cyc;

        // only core 1 requests for three cycles, then a tie must go to core 0
        drive_c1(1'b1, 1'b0, 4'd4, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            check_vec($sformatf("solo_c1_gnt_%0d", k), bus.c1_gnt, 1);
            check_vec($sformatf("solo_c0_gnt_%0d", k), bus.c0_gnt, 0);
            check_vec($sformatf("solo_addr_%0d", k), bus.mem_address, 4);
            check_vec($sformatf("solo_c0_rv_%0d", k), bus.c0_rvalid, 0);
            cyc;
        end
        drive_c0(1'b1, 1'b0, 4'd6, 32'h0, 1'b0);
        #2;
        check_vec("solo_tie_c0", bus.c0_gnt, 1);
        check_vec("solo_tie_c1", bus.c1_gnt, 0);
        check_vec("solo_c1_rv", bus.c1_rvalid, 1);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        check_vec("idle_c0_gnt", bus.c0_gnt, 0);
        check_vec("idle_c1_gnt", bus.c1_gnt, 0);
        check_vec("idle_addr", bus.mem_address, 0);
        check_vec("idle_wdata", bus.mem_wdata, 0);
        check_vec("idle_c0_rv", bus.c0_rvalid, 1);
        check_vec("idle_c0_rdata", bus.c0_rdata, 32'h1006);
        check_vec("idle_c1_rdata", bus.c1_rdata, 32'h1004);
        cyc;

        // locked read-modify-write by core 0 while core 1 waits on the same word
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        drive_c0(1'b1, 1'b0, 4'd5, 32'h0, 1'b1);
        drive_c1(1'b1, 1'b0, 4'd5, 32'h0, 1'b0);
        #2;
        check_vec("lk_a_c0_gnt", bus.c0_gnt, 1);
        check_vec("lk_a_c1_gnt", bus.c1_gnt, 0);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd5, 32'h0, 1'b1);
        #2;
        check_vec("lk_b_c1_gnt", bus.c1_gnt, LOCK_ON ? 0 : 1);
        check_vec("lk_b_c0_gnt", bus.c0_gnt, 0);
        check_vec("lk_b_c0_rv", bus.c0_rvalid, 1);
        check_vec("lk_b_c0_rdata", bus.c0_rdata, 32'h1005);
        cyc;
        drive_c0(1'b1, 1'b1, 4'd5, 32'hA5A5A5A5, 1'b0);
        #2;
        check_vec("lk_c_c0_gnt", bus.c0_gnt, 1);
        check_vec("lk_c_c1_gnt", bus.c1_gnt, 0);
        check_vec("lk_c_store", bus.mem_store, 1);
        check_vec("lk_c_c1_rv", bus.c1_rvalid, LOCK_ON ? 0 : 1);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        check_vec("lk_d_c1_gnt", bus.c1_gnt, 1);
        check_vec("lk_d_addr", bus.mem_address, 5);
        cyc;
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        #2;
        check_vec("lk_e_c1_rv", bus.c1_rvalid, 1);
        check_vec("lk_e_c1_rdata", bus.c1_rdata, 32'hA5A5A5A5);
        cyc;

        // reset lands while a load is pending: rvalid, rdata and ptr all cleared
        drive_c0(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        #2;
        check_vec("rs_w_c0_gnt", bus.c0_gnt, 1);
        cyc;
        reset = 1'b1;
        drive_c1(1'b1, 1'b0, 4'd2, 32'h0, 1'b0);
        #2;
        check_vec("rs_x_c0_gnt", bus.c0_gnt, 0);
        check_vec("rs_x_c1_gnt", bus.c1_gnt, 0);
        check_vec("rs_x_load", bus.mem_load, 0);
        cyc;
        reset = 1'b0;
        #2;
        check_vec("rs_y_c0_gnt", bus.c0_gnt, 1);
        check_vec("rs_y_c1_gnt", bus.c1_gnt, 0);
        check_vec("rs_y_c0_rv", bus.c0_rvalid, 0);
        check_vec("rs_y_c0_rdata", bus.c0_rdata, 0);
        check_vec("rs_y_c1_rdata", bus.c1_rdata, 0);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        cyc;

        // reset drops ownership taken by a locked core 1 access
        drive_c1(1'b1, 1'b0, 4'd2, 32'h0, 1'b1);
        #2;
        check_vec("ro_v_c1_gnt", bus.c1_gnt, 1);
        cyc;
        reset = 1'b1;
        drive_c0(1'b1, 1'b0, 4'd1, 32'h0, 1'b0);
        #2;
        check_vec("ro_x_c0_gnt", bus.c0_gnt, 0);
        check_vec("ro_x_c1_gnt", bus.c1_gnt, 0);
        cyc;
        reset = 1'b0;
        #2;
        check_vec("ro_y_c0_gnt", bus.c0_gnt, 1);
        check_vec("ro_y_c1_gnt", bus.c1_gnt, 0);
        check_vec("ro_y_c1_rv", bus.c1_rvalid, 0);
        cyc;
        drive_c0(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        drive_c1(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        cyc;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between core 0 and core 1 in the two-core system. Each cycle it grants at most one core's load or store, drives the memory's address, write-data and load/store controls for the granted core, and captures asynchronous read data into a per-core return register. Round-robin fairness is used, with optional lock ownership for atomic read-modify-write sequences used by the coherence protocol.

## Interface
- ADDR_W, 4, word address width (matches memory depth 1<<ADDR_W)
- DATA_W, 32, data width
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- c0_req / c1_req  input  1  core requests an access; held until granted
- c0_we / c1_we  input  1  1 = store, 0 = load
- c0_addr / c1_addr  input  ADDR_W  word address
- c0_wdata / c1_wdata  input  DATA_W  store data
- c0_lock / c1_lock  input  1  request/retain exclusive ownership (only with lock feature)
- c0_gnt / c1_gnt  output  1  combinational grant; access happens this cycle
- c0_rdata / c1_rdata  output  DATA_W  registered load data
- c0_rvalid / c1_rvalid  output  1  one-cycle pulse, rdata updated
- mem_address  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory write data
- mem_load  output  1  to memory load_control
- mem_store  output  1  to memory store_control
- mem_rdata  input  DATA_W  from memory (asynchronous read)

## Operation
- State: priority pointer ptr (0/1), ownership state own ∈ {FREE, OWN0, OWN1}, per-core rdata/rvalid registers.
- Grant (combinational): own=OWN0 → only core 0 may be granted; OWN1 → only core 1; FREE → single requester granted; both requesting → core ptr granted.
- At most one gnt high per cycle; no gnt during reset.
- Granted core's addr/wdata drive mem_address/mem_wdata; mem_store = gnt & we; mem_load = gnt & ~we. No grant → mem_load = mem_store = 0, mem_address and mem_wdata = 0.
- Granted load: mem_rdata captured into that core's rdata at the edge; its rvalid high the following cycle only. Stores never pulse rvalid. rdata holds the last loaded value otherwise.
- Store commits in memory at the grant edge; a load by the other core granted next cycle returns the new value.
- ptr: after any grant to core i, ptr ← other core. No grant → ptr unchanged.
- Ungranted requester stalls, keeping req/we/addr/wdata stable; arbiter does not queue.

## Timing
- Grant-to-store commit: same edge. Grant-to-rvalid: 1 cycle. Back-to-back grants to alternating cores every cycle sustainable.
- Reset values: c*_gnt 0, c*_rvalid 0, c*_rdata 0, mem_load/mem_store 0, mem_address 0, mem_wdata 0, ptr 0, own FREE.
- Reset asserted mid-sequence: all state reset at that edge, ownership dropped, pending rvalid suppressed.
- Request deasserted in same cycle as possible grant: no grant, ptr unchanged.

## Configuration
- DMEM_ARB_LOCK_EN defined: granted core with lock=1 moves own to OWN<i> at that edge. Owner keeps ownership, even while idle, until it drops lock; own → FREE at the edge lock is sampled low. Lock without a grant is ignored in FREE.
- Undefined: c*_lock ignored, own stays FREE, pure round-robin.

## Test plan
- Reset, then core 0 stores 0xDEADBEEF to addr 3 → c0_gnt=1, mem_store=1, mem_address=3 that cycle; core 1 loads addr 3 next cycle → c1_rvalid one cycle later, c1_rdata=0xDEADBEEF.
- Both cores load every cycle from reset → grants alternate 0,1,0,1; each rvalid pulses one cycle after its grant.
- Only core 1 requests for 3 cycles → c1_gnt=1 all 3 cycles; ptr ends at 0; no c0 activity.
- Lock (macro on): core 0 load addr 5 with lock, core 1 requesting → core 1 stalled until core 0 stores addr 5 and drops lock; core 1 granted the cycle after lock low. Macro off: same stimulus alternates grants.
- Reset asserted the cycle a load is granted → no rvalid next cycle, rdata 0, ptr 0, own FREE.
